// File: rtl/tone_generator.sv
// Square-wave tone generator. A request latches the tone frequency, a
// 32-step restoring divider turns it into a half-period in clock cycles,
// and a phase counter then toggles the speaker every half-period.
module tone_generator #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned MIN_FREQ = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sound,
    input  logic [9:0]  frequency,
    output logic        speaker,
    output logic        playing,
    output logic [31:0] half_period
);

    typedef enum logic [1:0] {
        SILENT,
        CALC,
        PLAY
    } state_t;

    // Dividend of the half-period division: cycles in half a second.
    localparam logic [31:0] HALF_CLK = 32'(CLK_HZ / 2);

    state_t      state_q, state_d;
    logic [9:0]  freq_q, freq_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] phase_q, phase_d;
    logic        speaker_q, speaker_d;
    logic [31:0] half_period_q, half_period_d;

    logic        valid;
    logic        freq_change;
    logic [33:0] rem_shift;
    logic        fits;
    logic [31:0] quot_next;

    assign valid       = sound && ({22'd0, frequency} >= MIN_FREQ);
    assign freq_change = (frequency != freq_q);

    // One restoring-divider step: shift in the next dividend bit and
    // subtract the divisor when it fits.
    assign rem_shift = {rem_q, HALF_CLK[idx_q]};
    assign fits      = (rem_shift >= {24'd0, freq_q});
    assign quot_next = quot_q | ({31'd0, fits} << idx_q);

    // Next-state and datapath decisions; every register holds unless told otherwise.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        freq_d        = freq_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        idx_d         = idx_q;
        phase_d       = phase_q;
        speaker_d     = speaker_q;
        half_period_d = half_period_q;

        case (state_q)
            SILENT: begin
                speaker_d = 1'b0;
                if (valid) begin
                    freq_d  = frequency;
                    rem_d   = '0;
                    quot_d  = '0;
                    idx_d   = 5'd31;
                    state_d = CALC;
                end
            end

            CALC: begin
                speaker_d = 1'b0;
                if (!valid) begin
                    state_d = SILENT;
                end else if (freq_change) begin
                    freq_d = frequency;
                    rem_d  = '0;
                    quot_d = '0;
                    idx_d  = 5'd31;
                end else begin
                    rem_d  = fits ? 33'(rem_shift - {24'd0, freq_q}) : rem_shift[32:0];
                    quot_d = quot_next;
                    idx_d  = idx_q - 5'd1;
                    if (idx_q == 5'd0) begin
                        // A zero quotient would stall the phase compare; clamp to 1.
                        half_period_d = (quot_next == 32'd0) ? 32'd1 : quot_next;
                        phase_d       = '0;
                        speaker_d     = 1'b1;
                        state_d       = PLAY;
                    end
                end
            end

            PLAY: begin
                if (!valid) begin
                    speaker_d = 1'b0;
                    state_d   = SILENT;
                end else if (freq_change) begin
                    speaker_d = 1'b0;
                    freq_d    = frequency;
                    rem_d     = '0;
                    quot_d    = '0;
                    idx_d     = 5'd31;
                    state_d   = CALC;
                end else if (phase_q == half_period_q - 32'd1) begin
                    speaker_d = ~speaker_q;
                    phase_d   = '0;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end

            default: begin
                speaker_d = 1'b0;
                state_d   = SILENT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q       <= SILENT;
            freq_q        <= '0;
            rem_q         <= '0;
            quot_q        <= '0;
            idx_q         <= '0;
            phase_q       <= '0;
            speaker_q     <= 1'b0;
            half_period_q <= '0;
        end else begin
            state_q       <= state_d;
            freq_q        <= freq_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            idx_q         <= idx_d;
            phase_q       <= phase_d;
            speaker_q     <= speaker_d;
            half_period_q <= half_period_d;
        end
    end

    assign speaker     = speaker_q;
    assign playing     = (state_q == PLAY);
    assign half_period = half_period_q;

endmodule

// File: doc/tone_generator.md
# tone_generator

Square-wave tone generator that sits directly downstream of the colour-to-tone mapper. It takes the mapper's `sound` enable and 10-bit `frequency` (Hz) and drives a 1-bit speaker/buzzer pin. On each new tone request it computes the half-period with a sequential restoring divider, then toggles the speaker output with a cycle counter. Tone changes and silence requests are glitch-free.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz; must satisfy 2 ≤ CLK_HZ < 2^32.
- `MIN_FREQ`, default 20: lowest accepted tone in Hz; lower values are treated as silence.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sound`  in  1: tone request from the mapper.
- `frequency`  in  10: requested tone in Hz, 0..1023.
- `speaker`  out  1: square-wave drive to the buzzer.
- `playing`  out  1: high while in state PLAY.
- `half_period`  out  32: latched half-period in clock cycles, for debug and verification.

## Operation
- Constant: HALF_CLK = CLK_HZ/2 (integer division), held as a 32-bit dividend.
- "Valid request" means `sound`=1 and `frequency` ≥ MIN_FREQ.
- The FSM has three states: SILENT, CALC and PLAY.
- **SILENT**
  - `speaker`=0 and `playing`=0.
  - On a valid request: latch `frequency` into freq_q, clear the divider (remainder=0, quotient=0, bit index=31), and go to CALC.
- **CALC**
  - Performs one restoring-divider iteration per cycle, 32 iterations in total: HALF_CLK / freq_q.
  - Remainder is 33 bits wide; quotient is 32 bits wide.
  - `speaker`=0 and `playing`=0.
  - After the last iteration:
    - `half_period` = quotient, clamped to a minimum of 1.
    - Phase counter = 0.
    - `speaker`=1.
    - Go to PLAY.
  - If the request becomes invalid, go to SILENT (abort; `half_period` is unchanged).
  - If a valid request arrives with `frequency` ≠ freq_q, relatch and restart CALC from iteration 0.
- **PLAY**
  - `playing`=1.
  - The 32-bit phase counter increments every cycle.
  - When counter == `half_period`−1: toggle `speaker` and reset the counter to 0.
  - If the request becomes invalid: go to SILENT, with `speaker`=0 on the same edge.
  - If a valid request arrives with `frequency` ≠ freq_q: relatch, go to CALC, with `speaker`=0 on the same edge.
- Priority on any edge: `rst` > invalid request > frequency change > normal progress.
- `half_period` holds its last value across SILENT. It is rewritten only when a CALC run completes.

## Timing
- Reset values (one edge with `rst`=1): state SILENT, `speaker`=0, `playing`=0, `half_period`=0, counters 0. This applies from any state, including mid-CALC or mid-PLAY.
- Inputs are sampled only at rising edges. There is no combinational path from inputs to outputs.
- Latency: call the edge that first samples a valid request edge 1.
  - CALC iterations occur on edges 2..33.
  - `speaker` and `playing` rise on edge 33.
  - `half_period` is valid from edge 33.
- In PLAY each level lasts exactly `half_period` cycles. The period is 2×`half_period` cycles.
- Silence latency: `sound` falling at edge N gives `speaker`=0 and `playing`=0 after edge N.
- Frequency-change gap: the output is silent for exactly 32 cycles, then the new tone starts high.
- Arithmetic:
  - The quotient is a floor division.
  - Counter compare is unsigned 32-bit.
  - The clamp to 1 prevents a zero half-period at tiny CLK_HZ.

## Test plan
- Basic tone (CLK_HZ=1_000_000): `sound`=1, `frequency`=440 → `speaker` rises 33 edges after the request, `half_period`=1136, levels last 1136 cycles each.
- All four tones (CLK_HZ=1_000_000): 494, 523 and 587 → `half_period` = 1012, 956 and 851 respectively; default CLK_HZ with 440 → 56818.
- Mid-CALC change: switch 440→587 at iteration 10 → CALC restarts, `speaker` rises 32 edges after the change edge, `half_period`=851 (CLK_HZ=1_000_000).
- Silence and below-minimum: in PLAY drop `sound` → `speaker`=0 and `playing`=0 after that edge; `sound`=1 with `frequency`=15 → remains SILENT.
- Reset mid-operation: assert `rst` during CALC and again during PLAY with `speaker`=1 → all outputs 0 after one edge, no tone until a new request.
- Clamp (CLK_HZ=1000): `frequency`=1023 → `half_period`=1, `speaker` toggles every cycle.
